// File: rtl/usb_pkg.sv
// Shared types and defaults for the USB receive datapath.
// The word struct is sized for the widest supported word; narrower instances zero-fill it.
package usb_pkg;

   localparam int unsigned UsbRxWidth = 64;
   localparam int unsigned UsbRxCntW  = $clog2(UsbRxWidth + 1);

   typedef enum logic [0:0] {
      IDLE,
      RECV
   } rx_state_t;

   typedef struct packed {
      logic [UsbRxWidth-1:0] data;
      logic [UsbRxCntW-1:0]  bit_count;
      logic                  last;
   } rx_word_t;

endpackage

// File: rtl/rx_word_buffer.sv
// Single-entry output register with valid/ready handshake.
// A load while a word is held and not being accepted overwrites it and pulses ovf_strobe.
module rx_word_buffer
   import usb_pkg::*;
(
   input  logic     clock,
   input  logic     rst_L,
   input  logic     load,
   input  rx_word_t word_in,
   input  logic     out_ready,
   output rx_word_t word_out,
   output logic     out_valid,
   output logic     ovf_strobe
);

   rx_word_t word_q;
   logic     valid_q;

   always_comb begin
      ovf_strobe = load && valid_q && !out_ready;
   end

   always_ff @(posedge clock or negedge rst_L) begin
      if (!rst_L) begin
         word_q  <= '0;
         valid_q <= 1'b0;
      end else if (load) begin
         word_q  <= word_in;
         valid_q <= 1'b1;
      end else if (valid_q && out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign word_out  = word_q;
   assign out_valid = valid_q;

endmodule

// File: rtl/usb_rx_deserializer.sv
// Collects the unstuffed LSB-first USB bit stream into parallel words.
// The first received bit of each word lands in bit 0; words leave through rx_word_buffer.
module usb_rx_deserializer
   import usb_pkg::*;
#(
   parameter int unsigned WIDTH = UsbRxWidth,
   parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             rst_L,
   input  logic             start,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic             eop,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out,
   output logic [CW-1:0]    bit_count,
   output logic             out_valid,
   output logic             out_last,
   output logic             overflow,
   output logic             busy
);

   rx_state_t        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d, cnt_nx;
   logic [WIDTH-1:0] asm_q, asm_d, asm_tmp;
   logic             ovf_q, ovf_d;
   logic             load;
   logic             ovf_strobe;
   rx_word_t         word_d, word_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      asm_d   = asm_q;
      asm_tmp = asm_q;
      cnt_nx  = cnt_q;
      load    = 1'b0;
      word_d  = '0;
      if (start) begin
         // Start wins over everything, including a bit arriving in the same cycle.
         state_d = RECV;
         cnt_d   = '0;
         asm_d   = '0;
      end else if (state_q == RECV) begin
         if (bit_valid) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
               if (cnt_q == CW'(i)) asm_tmp[i] = bit_in;
            end
            cnt_nx = cnt_q + CW'(1);
         end
         if (cnt_nx == CW'(WIDTH)) begin
            load                     = 1'b1;
            word_d.data[WIDTH-1:0]   = asm_tmp;
            word_d.bit_count[CW-1:0] = cnt_nx;
            word_d.last              = eop;
            cnt_d                    = '0;
            asm_d                    = '0;
         end else if (eop) begin
            load                     = 1'b1;
            word_d.data[WIDTH-1:0]   = asm_tmp;
            word_d.bit_count[CW-1:0] = cnt_nx;
            word_d.last              = 1'b1;
            cnt_d                    = '0;
            asm_d                    = '0;
         end else begin
            cnt_d = cnt_nx;
            asm_d = asm_tmp;
         end
         if (eop) state_d = IDLE;
      end
      ovf_d = start ? 1'b0 : (ovf_q | ovf_strobe);
   end

   always_ff @(posedge clock or negedge rst_L) begin
      if (!rst_L) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         asm_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         ovf_q   <= ovf_d;
      end
   end

   rx_word_buffer u_buf (
      .clock      (clock),
      .rst_L      (rst_L),
      .load       (load),
      .word_in    (word_d),
      .out_ready  (out_ready),
      .word_out   (word_q),
      .out_valid  (out_valid),
      .ovf_strobe (ovf_strobe)
   );

   assign data_out  = word_q.data[WIDTH-1:0];
   assign bit_count = word_q.bit_count[CW-1:0];
   assign out_last  = word_q.last;
   assign overflow  = ovf_q;
   assign busy      = (state_q == RECV);

endmodule
